// File: rtl/spkr_reg_arbiter.sv
// Round-robin arbiter sharing the speaker register AXI4-Lite port between two requesters.
// Optional error counter enabled by defining SPKR_ARB_ERR_CNT_EN.
module spkr_reg_arbiter #(
  parameter int                       C_ADDR_WIDTH = 32,
  parameter int                       C_DATA_WIDTH = 32,
  parameter logic [C_ADDR_WIDTH-1:0]  C_BASE_ADDR  = 32'h0000_0000
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
`ifdef SPKR_ARB_ERR_CNT_EN
  input  logic                      err_clr,
  output logic [15:0]               err_count,
`endif
  input  logic [1:0]                req_valid,
  input  logic [1:0]                req_we,
  input  logic [1:0]                req_idx0,
  input  logic [1:0]                req_idx1,
  input  logic [C_DATA_WIDTH-1:0]   req_wdata0,
  input  logic [C_DATA_WIDTH-1:0]   req_wdata1,
  output logic [1:0]                req_ack,
  output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                M_AXI_AWPROT,
  output logic                      M_AXI_AWVALID,
  input  logic                      M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [3:0]                M_AXI_WSTRB,
  output logic                      M_AXI_WVALID,
  input  logic                      M_AXI_WREADY,
  input  logic [1:0]                M_AXI_BRESP,
  input  logic                      M_AXI_BVALID,
  output logic                      M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                M_AXI_ARPROT,
  output logic                      M_AXI_ARVALID,
  input  logic                      M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                M_AXI_RRESP,
  input  logic                      M_AXI_RVALID,
  output logic                      M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WRESP = 3'd2,
    S_READ  = 3'd3,
    S_RDATA = 3'd4,
    S_ACK   = 3'd5
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic                      grant_r;
  logic                      ptr_r;
  logic                      grant_s;
  logic                      any_req_s;
  logic [1:0]                idx_s;
  logic [C_DATA_WIDTH-1:0]   wdata_s;
  logic [C_ADDR_WIDTH-1:0]   addr_s;
  logic                      aw_done_s;
  logic                      w_done_s;
  logic                      awvalid_r;
  logic                      wvalid_r;
  logic                      bready_r;
  logic                      arvalid_r;
  logic                      rready_r;
  logic [C_ADDR_WIDTH-1:0]   awaddr_r;
  logic [C_ADDR_WIDTH-1:0]   araddr_r;
  logic [C_DATA_WIDTH-1:0]   wdata_r;
  logic [C_DATA_WIDTH-1:0]   rsp_rdata_r;
  logic [1:0]                rsp_resp_r;
  logic [1:0]                ack_r;

  // Grant selection, request mux and write-handshake completion
  always_comb begin
    any_req_s = |req_valid;
    grant_s   = 1'b0;
    if (req_valid == 2'b11) begin
      grant_s = ptr_r;
    end else if (req_valid[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (grant_s) begin
      idx_s   = req_idx1;
      wdata_s = req_wdata1;
    end else begin
      idx_s   = req_idx0;
      wdata_s = req_wdata0;
    end
    addr_s    = C_BASE_ADDR + {{(C_ADDR_WIDTH-4){1'b0}}, idx_s, 2'b00};
    // A VALID that is already low has completed its handshake earlier
    aw_done_s = ~awvalid_r | M_AXI_AWREADY;
    w_done_s  = ~wvalid_r | M_AXI_WREADY;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (any_req_s) begin
          if (req_we[grant_s]) begin
            state_s = S_WRITE;
          end else begin
            state_s = S_READ;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WRITE: begin
        if (aw_done_s && w_done_s) begin
          state_s = S_WRESP;
        end else begin
          state_s = S_WRITE;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          state_s = S_ACK;
        end else begin
          state_s = S_WRESP;
        end
      end
      S_READ: begin
        if (M_AXI_ARREADY) begin
          state_s = S_RDATA;
        end else begin
          state_s = S_READ;
        end
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          state_s = S_ACK;
        end else begin
          state_s = S_RDATA;
        end
      end
      S_ACK:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State register and per-state handshake outputs
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r   <= S_IDLE;
      bready_r  <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      ack_r     <= 2'b00;
    end else begin
      state_r   <= state_s;
      bready_r  <= (state_s == S_WRESP);
      arvalid_r <= (state_s == S_READ);
      rready_r  <= (state_s == S_RDATA);
      ack_r     <= (state_s == S_ACK) ? (grant_r ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  // Grant capture, round-robin pointer and write-channel VALIDs
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      grant_r   <= 1'b0;
      ptr_r     <= 1'b0;
      awaddr_r  <= '0;
      araddr_r  <= '0;
      wdata_r   <= '0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
    end else if (state_r == S_IDLE && any_req_s) begin
      grant_r <= grant_s;
      ptr_r   <= ~grant_s;
      if (req_we[grant_s]) begin
        awaddr_r  <= addr_s;
        wdata_r   <= wdata_s;
        awvalid_r <= 1'b1;
        wvalid_r  <= 1'b1;
      end else begin
        araddr_r <= addr_s;
      end
    end else begin
      if (awvalid_r && M_AXI_AWREADY) begin
        awvalid_r <= 1'b0;
      end
      if (wvalid_r && M_AXI_WREADY) begin
        wvalid_r <= 1'b0;
      end
    end
  end

  // Response capture; writes return zero read data
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rsp_rdata_r <= '0;
      rsp_resp_r  <= 2'b00;
    end else if (state_r == S_WRESP && M_AXI_BVALID) begin
      rsp_rdata_r <= '0;
      rsp_resp_r  <= M_AXI_BRESP;
    end else if (state_r == S_RDATA && M_AXI_RVALID) begin
      rsp_rdata_r <= M_AXI_RDATA;
      rsp_resp_r  <= M_AXI_RRESP;
    end
  end

`ifdef SPKR_ARB_ERR_CNT_EN
  logic [15:0] err_count_r;

  // Saturating count of non-OKAY responses; clear wins over increment
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_count_r <= 16'h0000;
    end else if (err_clr) begin
      err_count_r <= 16'h0000;
    end else if (state_r == S_ACK && rsp_resp_r != 2'b00 && err_count_r != 16'hFFFF) begin
      err_count_r <= err_count_r + 16'h0001;
    end
  end

  assign err_count = err_count_r;
`endif

  assign req_ack       = ack_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_resp      = rsp_resp_r;
  assign M_AXI_AWADDR  = awaddr_r;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_r;
  assign M_AXI_WDATA   = wdata_r;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_r;
  assign M_AXI_BREADY  = bready_r;
  assign M_AXI_ARADDR  = araddr_r;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_r;
  assign M_AXI_RREADY  = rready_r;

endmodule
